// File: rtl/fifo1_enq_arbiter_if.sv
// fifo1_enq_arbiter_if
//   Bundles the producer-side request/enqueue signals and the FIFO enqueue
//   method signals for fifo1_enq_arbiter.
//   slave  : arbiter view. It takes in the requests and FIFO RDY, and drives the
//            grants and the FIFO enqueue.
//   master : environment view. This is the producers plus the FIFO.
//   Signals:
//     req_valid / req_lock / req_enq__ENA [NUM_REQ]   producer requests
//     req_enq_v [NUM_REQ*DATA_WIDTH]                  producer payloads, slice i
//     req_enq__RDY [NUM_REQ]                          one-hot grant
//     fifo_enq__RDY                                   FIFO not full
//     fifo_enq__ENA / fifo_enq_v / fifo_enq_src       enqueue strobe, payload, source
interface fifo1_enq_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            req_enq__ENA;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_enq_v;
  logic [NUM_REQ-1:0]            req_enq__RDY;
  logic                          fifo_enq__RDY;
  logic                          fifo_enq__ENA;
  logic [DATA_WIDTH-1:0]         fifo_enq_v;
  logic [$clog2(NUM_REQ)-1:0]    fifo_enq_src;

  modport master (
    output req_valid, req_lock, req_enq__ENA, req_enq_v, fifo_enq__RDY,
    input  req_enq__RDY, fifo_enq__ENA, fifo_enq_v, fifo_enq_src
  );

  modport slave (
    input  req_valid, req_lock, req_enq__ENA, req_enq_v, fifo_enq__RDY,
    output req_enq__RDY, fifo_enq__ENA, fifo_enq_v, fifo_enq_src
  );
endinterface

// File: rtl/fifo1_enq_arbiter.sv
// fifo1_enq_arbiter
//   This is a round-robin arbiter that shares one single-element FIFO enqueue
//   port among NUM_REQ producers. The grant is combinational and has zero
//   latency. The winner's data and a source tag are forwarded to the FIFO.
//   A producer may lock the port for up to LOCK_MAX back-to-back beats, which
//   keeps multi-beat messages contiguous.
//   Ports:
//     CLK, nRST     clock; synchronous active-low reset
//     bus (slave)   requests, grants and FIFO enqueue (see fifo1_enq_arbiter_if)
//     locked        registered, high while a producer holds the lock
//     protocol_err  registered one-cycle pulse when an ENA arrives without its RDY
module fifo1_enq_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 4
)(
  input  logic               CLK,
  input  logic               nRST,
  fifo1_enq_arbiter_if.slave bus,
  output logic               locked,
  output logic               protocol_err
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {ARB, LOCKED} st_t;

  st_t                                 st, st_nxt;
  logic [SRC_W-1:0]                    rr_ptr, rr_nxt, owner, owner_nxt;
  logic [SRC_W-1:0]                    winner, cand;
  logic [CNT_W-1:0]                    lock_cnt, cnt_nxt, cnt_inc;
  logic [NUM_REQ-1:0]                  grant;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  slice;
  logic                                xfer;

  assign slice = bus.req_enq_v;

  // Winner selection. The scan runs farthest to nearest, so the last hit is
  // the first valid port after rr_ptr.
  always_comb begin
    winner = owner;
    cand   = '0;
    if (st == ARB) begin
      winner = rr_ptr;
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (bus.req_valid[cand]) winner = cand;
      end
    end
  end

  // The grant never looks at ENA. It is killed during reset and while the FIFO is full.
  always_comb begin
    grant = '0;
    if (nRST && bus.fifo_enq__RDY)
      grant[winner] = bus.req_valid[winner];
  end

  assign xfer              = |(bus.req_enq__ENA & grant);
  assign bus.req_enq__RDY  = grant;
  assign bus.fifo_enq__ENA = xfer;
  assign bus.fifo_enq_v    = slice[winner];
  assign bus.fifo_enq_src  = winner;

  assign cnt_inc = lock_cnt + CNT_W'(1);

  always_comb begin
    st_nxt    = st;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    cnt_nxt   = lock_cnt;
    case (st)
      ARB: begin
        if (xfer) begin
          rr_nxt = winner;
          if (bus.req_lock[winner]) begin
            st_nxt    = LOCKED;
            owner_nxt = winner;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        // Leaving the lock always leaves rr_ptr at owner, so the next scan starts at owner+1.
        if (!bus.req_valid[owner]) begin
          st_nxt  = ARB;
          cnt_nxt = '0;
          rr_nxt  = owner;
        end else if (xfer) begin
          rr_nxt  = owner;
          cnt_nxt = cnt_inc;
          if (!bus.req_lock[owner] || cnt_inc == CNT_W'(LOCK_MAX)) begin
            st_nxt  = ARB;
            cnt_nxt = '0;
          end
        end
        // If the FIFO is full, or the owner waits without ENA, the lock is held and the count is frozen.
      end
      default: st_nxt = ARB;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      st           <= ARB;
      rr_ptr       <= SRC_W'(NUM_REQ - 1);
      owner        <= '0;
      lock_cnt     <= '0;
      protocol_err <= 1'b0;
    end else begin
      st           <= st_nxt;
      rr_ptr       <= rr_nxt;
      owner        <= owner_nxt;
      lock_cnt     <= cnt_nxt;
      protocol_err <= |(bus.req_enq__ENA & ~grant);
    end
  end

  assign locked = (st == LOCKED);

endmodule
